muldiv_unit: RTL

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 39 +++
 rtl/muldiv_divcore.sv | 37 +++
 rtl/muldiv_unit.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit:
// funct3 codes, FSM encoding, iteration count, operand helpers.
package muldiv_pkg;

  localparam int XLEN  = 32;
  localparam int ITERS = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic a_signed(input logic [2:0] f);
    return !(f == F3_MULHU || f == F3_DIVU || f == F3_REMU);
  endfunction

  function automatic logic b_signed(input logic [2:0] f);
    return f == F3_MUL || f == F3_MULH ||
           f == F3_DIV || f == F3_REM;
  endfunction

  function automatic logic [XLEN-1:0] mag(
    input logic [XLEN-1:0] x,
    input logic            sgn
  );
    return (sgn && x[XLEN-1]) ? (~x + 1'b1) : x;
  endfunction

endpackage

// File: rtl/muldiv_divcore.sv
// Restoring divide step on magnitudes plus divide-by-zero and
// signed-overflow detection; only present when MULDIV_DIV_EN is set.
`ifdef MULDIV_DIV_EN
module muldiv_divcore
  import muldiv_pkg::*;
(
  input  logic [XLEN-1:0] rem_cur,
  input  logic [XLEN-1:0] quo_cur,
  input  logic [XLEN-1:0] divisor,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            sgn,
  output logic [XLEN-1:0] rem_nxt,
  output logic [XLEN-1:0] quo_nxt,
  output logic            div_zero,
  output logic            overflow
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;
  logic          ge;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    shifted = {rem_cur, quo_cur[XLEN-1]};
    diff    = shifted - {1'b0, divisor};
    ge      = shifted >= {1'b0, divisor};
    rem_nxt = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    quo_nxt = {quo_cur[XLEN-2:0], ge};
  end

  assign div_zero = (op_b == '0);
  assign overflow = sgn && (op_a == 32'h8000_0000) &&
                    (op_b == 32'hFFFF_FFFF);

endmodule
`endif

// File: rtl/muldiv_unit.sv
// RV32M iterative multiply/divide, fixed 33-cycle latency.
// Division compiled in only when MULDIV_DIV_EN is defined.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  ready,
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] op_a,
  input  logic [DATA_WIDTH-1:0] op_b,
  input  logic [4:0]            rd_addr,
  input  logic                  kill,
  output logic                  wr_en,
  output logic [4:0]            wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  illegal
);

  state_t            state;
  state_t            state_nxt;
  logic [4:0]        cnt;
  logic [2:0]        op;
  logic [4:0]        rd;
  logic [XLEN-1:0]   mc;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] acc_step;
  logic [2*XLEN-1:0] mul_nxt;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   result;
  logic              neg_a;
  logic              neg_b;
  logic              illegal_q;
  logic              accept;
  logic              go_calc;
  logic              bad_op;

  assign accept = start && !kill && (state == S_IDLE);

`ifdef MULDIV_DIV_EN
  logic [XLEN-1:0] rem_nxt;
  logic [XLEN-1:0] quo_nxt;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;
  logic            div_zero;
  logic            overflow;
  logic            dz_q;
  logic            ovf_q;

  muldiv_divcore u_divcore (
    .rem_cur  (acc[2*XLEN-1:XLEN]),
    .quo_cur  (acc[XLEN-1:0]),
    .divisor  (mc),
    .op_a     (op_a),
    .op_b     (op_b),
    .sgn      (!funct3[0]),
    .rem_nxt  (rem_nxt),
    .quo_nxt  (quo_nxt),
    .div_zero (div_zero),
    .overflow (overflow)
  );

  assign bad_op   = 1'b0;
  assign acc_step = op[2] ? {rem_nxt, quo_nxt} : mul_nxt;
`else
  assign bad_op   = funct3[2];
  assign acc_step = mul_nxt;
`endif

  assign go_calc = accept && !bad_op;

  // Shift-add step: add multiplicand on the low bit, shift right.
  always_comb begin
    mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} +
              (acc[0] ? {1'b0, mc} : '0);
    mul_nxt = {mul_sum, acc[XLEN-1:1]};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; kill overrides everything.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (go_calc) state_nxt = S_CALC;
      S_CALC: if (cnt == 5'(ITERS-1)) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (kill) state_nxt = S_IDLE;
  end

  // Operand capture on accept, then one iteration per CALC cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      op        <= '0;
      rd        <= '0;
      mc        <= '0;
      acc       <= '0;
      neg_a     <= 1'b0;
      neg_b     <= 1'b0;
      illegal_q <= 1'b0;
`ifdef MULDIV_DIV_EN
      dz_q      <= 1'b0;
      ovf_q     <= 1'b0;
`endif
    end else begin
      illegal_q <= accept && bad_op;
      if (go_calc) begin
        cnt   <= '0;
        op    <= funct3;
        rd    <= rd_addr;
        mc    <= mag(op_b, b_signed(funct3));
        acc   <= {{XLEN{1'b0}}, mag(op_a, a_signed(funct3))};
        neg_a <= a_signed(funct3) && op_a[XLEN-1];
        neg_b <= b_signed(funct3) && op_b[XLEN-1];
`ifdef MULDIV_DIV_EN
        dz_q  <= div_zero;
        ovf_q <= overflow;
`endif
      end else if (state == S_CALC && !kill) begin
        cnt <= cnt + 5'd1;
        acc <= acc_step;
      end
    end
  end

  // Sign correction and result select, including divide special cases.
  always_comb begin
    prod = acc;
    if (neg_a ^ neg_b) prod = ~acc + 1'b1;
    result = (op == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
`ifdef MULDIV_DIV_EN
    quo = acc[XLEN-1:0];
    if (neg_a ^ neg_b) quo = ~acc[XLEN-1:0] + 1'b1;
    rem = acc[2*XLEN-1:XLEN];
    if (neg_a) rem = ~acc[2*XLEN-1:XLEN] + 1'b1;
    if (dz_q) begin
      quo = '1;
    end else if (ovf_q) begin
      quo = 32'h8000_0000;
      rem = '0;
    end
    if (op[2]) result = op[1] ? rem : quo;
`endif
  end

  assign ready   = !rst_n || (state == S_IDLE);
  assign busy    = rst_n && (state == S_CALC || state == S_DONE);
  assign wr_en   = rst_n && !kill && (state == S_DONE) && (rd != '0);
  assign wr_addr = wr_en ? rd : '0;
  assign wr_data = wr_en ? DATA_WIDTH'(result) : '0;
  assign illegal = rst_n && illegal_q;

endmodule
